// File: rtl/ram_arbiter.sv
// Two-client arbiter/sequencer for a single-port synchronous RAM.
// Define RAM_ARB_FIXED_PRIO_EN for fixed client-0 priority (default round-robin).
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;

  state_t              state_q, state_d;
  logic                cmd_we_q, cmd_we_d;
  logic                cmd_id_q, cmd_id_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]   rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_W-1:0]   rsp1_rdata_q, rsp1_rdata_d;
  logic                gnt1;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic                last_grant_q, last_grant_d;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_we_d     = cmd_we_q;
    cmd_id_d     = cmd_id_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    gnt1         = 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          gnt1 = !req0_valid;
`else
          gnt1 = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
          last_grant_d = gnt1;
`endif
          req0_ready = !gnt1;
          req1_ready = gnt1;
          cmd_id_d   = gnt1;
          cmd_we_d   = gnt1 ? req1_we    : req0_we;
          ram_we_d   = gnt1 ? req1_we    : req0_we;
          ram_addr_d = gnt1 ? req1_addr  : req0_addr;
          ram_din_d  = gnt1 ? req1_wdata : req0_wdata;
          state_d    = ACCESS;
        end
      end
      ACCESS: state_d = cmd_we_q ? IDLE : RD_WAIT;
      RD_WAIT: begin
        // RAM output is valid here; capture it for the owning client
        if (cmd_id_q) begin
          rsp1_rdata_d = ram_data_out;
          rsp1_valid_d = 1'b1;
        end else begin
          rsp0_rdata_d = ram_data_out;
          rsp0_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_we_q     <= 1'b0;
      cmd_id_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cmd_we_q     <= cmd_we_d;
      cmd_id_q     <= cmd_id_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_din_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_rdata  = rsp0_rdata_q;
  assign rsp1_rdata  = rsp1_rdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural RAM model.
// Expected write, grant and response streams are queued and checked by a monitor.
module tb_ram_arbiter;
  logic       clk = 0;
  logic       rst = 1;
  logic       req0_valid = 0, req0_we = 0;
  logic [3:0] req0_addr = 0;
  logic [7:0] req0_wdata = 0;
  logic       req1_valid = 0, req1_we = 0;
  logic [3:0] req1_addr = 0;
  logic [7:0] req1_wdata = 0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       ram_we, busy;
  logic [3:0] ram_addr;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out = 0;
  logic [7:0] mem [16];

  int n_chk = 0;
  int n_fail = 0;
  bit gnt_check = 0;
  logic [7:0]  exp_rsp0 [$];
  logic [7:0]  exp_rsp1 [$];
  logic [11:0] exp_wr [$];
  int          exp_gnt [$];

  ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_valid) begin
        if (exp_rsp0.size() == 0) chk("rsp0_unexpected", {24'd0, rsp0_rdata}, 32'hdead);
        else chk("rsp0_rdata", {24'd0, rsp0_rdata}, {24'd0, exp_rsp0.pop_front()});
      end
      if (rsp1_valid) begin
        if (exp_rsp1.size() == 0) chk("rsp1_unexpected", {24'd0, rsp1_rdata}, 32'hdead);
        else chk("rsp1_rdata", {24'd0, rsp1_rdata}, {24'd0, exp_rsp1.pop_front()});
      end
      if (ram_we) begin
        if (exp_wr.size() == 0) chk("ram_we_unexpected", {20'd0, ram_addr, ram_data_in}, 32'hdead);
        else chk("ram_write", {20'd0, ram_addr, ram_data_in}, {20'd0, exp_wr.pop_front()});
      end
      if (req0_ready && req1_ready) chk("both_ready", 32'd1, 32'd0);
      if (gnt_check && (req0_ready || req1_ready)) begin
        if (exp_gnt.size() == 0) chk("grant_unexpected", {31'd0, req1_ready}, 32'hdead);
        else chk("grant_order", {31'd0, req1_ready}, exp_gnt.pop_front());
      end
    end
  end

  task automatic drive(input int c, input logic we, input logic [3:0] a,
                       input logic [7:0] d);
    bit ok = 0;
    if (c == 0) begin
      req0_we = we; req0_addr = a; req0_wdata = d; req0_valid = 1;
    end else begin
      req1_we = we; req1_addr = a; req1_wdata = d; req1_valid = 1;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((c == 0 && req0_ready) || (c == 1 && req1_ready)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", c, 32'hffff);
    @(posedge clk);
    #1;
    if (c == 0) req0_valid = 0;
    else req1_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[1] = 8'h11;
    mem[2] = 8'h22;

    // Reset state
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("rst_req0_ready", {31'd0, req0_ready}, 0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 0);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 0);
    chk("rst_rsp0_rdata", {24'd0, rsp0_rdata}, 0);
    chk("rst_rsp1_rdata", {24'd0, rsp1_rdata}, 0);
    chk("rst_ram_we", {31'd0, ram_we}, 0);
    chk("rst_ram_addr", {28'd0, ram_addr}, 0);
    chk("rst_ram_data_in", {24'd0, ram_data_in}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    @(posedge clk); #1;

    // Write then read back, client 0
    exp_wr.push_back({4'd3, 8'hA5});
    exp_rsp0.push_back(8'hA5);
    drive(0, 1, 4'd3, 8'hA5);
    drive(0, 0, 4'd3, 8'h00);
    idle(4);

    // Simultaneous reads after reset: client 0 first
    do_reset();
    gnt_check = 1;
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    exp_rsp0.push_back(8'h11);
    exp_rsp1.push_back(8'h22);
    fork
      drive(0, 0, 4'd1, 8'h00);
      drive(1, 0, 4'd2, 8'h00);
    join
    idle(5);
    chk("t3_grants_done", exp_gnt.size(), 0);

    // Contending writes
    do_reset();
`ifdef RAM_ARB_FIXED_PRIO_EN
    foreach (exp_wr[i]) ;
    for (int i = 0; i < 3; i++) begin
      exp_gnt.push_back(0);
      exp_wr.push_back({4'(8 + i), 8'(8'hC0 + i)});
    end
    for (int i = 0; i < 3; i++) begin
      exp_gnt.push_back(1);
      exp_wr.push_back({4'(12 + i), 8'(8'hD0 + i)});
    end
`else
    for (int i = 0; i < 3; i++) begin
      exp_gnt.push_back(0);
      exp_gnt.push_back(1);
      exp_wr.push_back({4'(8 + i), 8'(8'hC0 + i)});
      exp_wr.push_back({4'(12 + i), 8'(8'hD0 + i)});
    end
`endif
    fork
      for (int i = 0; i < 3; i++) drive(0, 1, 4'(8 + i), 8'(8'hC0 + i));
      for (int j = 0; j < 3; j++) drive(1, 1, 4'(12 + j), 8'(8'hD0 + j));
    join
    idle(4);
    chk("t4_grants_done", exp_gnt.size(), 0);
    gnt_check = 0;
    chk("t4_mem_8", {24'd0, mem[8]}, 32'hC0);
    chk("t4_mem_E", {24'd0, mem[14]}, 32'hD2);

    // Reset during RD_WAIT discards the read
    drive(1, 0, 4'd2, 8'h00);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_ram_we", {31'd0, ram_we}, 0);
    chk("t5_rsp1_valid", {31'd0, rsp1_valid}, 0);
    idle(4);

    // Top address / all-ones data
    exp_wr.push_back({4'hF, 8'hFF});
    exp_rsp0.push_back(8'hFF);
    drive(0, 1, 4'hF, 8'hFF);
    drive(0, 0, 4'hF, 8'h00);
    idle(5);

    chk("rsp0_q_empty", exp_rsp0.size(), 0);
    chk("rsp1_q_empty", exp_rsp1.size(), 0);
    chk("wr_q_empty", exp_wr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
